// File: rtl/seq_detect_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
// Shared constants and helpers for the shared serial pattern detector:
//   - default pattern length and target pattern
//   - seven-segment encodings and the hex-to-segment function
//   - index-width helper used to size channel indices
// ---------------------------------------------------------------------------
package seq_det_pkg;

  localparam int                  DEF_PLEN    = 3;
  localparam logic [DEF_PLEN-1:0] DEF_PATTERN = 3'b011;

  // Segment bits are {dp,g,f,e,d,c,b,a}, active-high.
  localparam logic [7:0] SEG_RESET = 8'h3F;  // digit 0, dp off
  localparam logic       SEG_DP_ON = 1'b1;

  // Width of an index into n items; never less than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Hex digit to {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seq_detect_arbiter_if.sv
// ---------------------------------------------------------------------------
// seq_detect_arbiter_if
// Per-channel serial bit handshake between the board inputs and the detector.
//   bit_in     serial data bit, one per channel
//   bit_valid  channel presents bit_in
//   bit_ready  one-hot grant; transfer when bit_valid & bit_ready
// master: the bit sources; slave: the detector.
// ---------------------------------------------------------------------------
interface seq_detect_arbiter_if #(
  parameter int NCH = 4
);
  logic [NCH-1:0] bit_in;
  logic [NCH-1:0] bit_valid;
  logic [NCH-1:0] bit_ready;

  modport master (output bit_in, output bit_valid, input bit_ready);
  modport slave  (input bit_in, input bit_valid, output bit_ready);
endinterface

// File: rtl/seq_detect_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first requesting index found when
// searching upward from ptr, wrapping modulo N.
//   req   in   N        request vector
//   ptr   in   idx_w(N) search start index
//   gnt   out  N        one-hot grant (all zero when nothing requests)
//   gidx  out  idx_w(N) encoded index of the grant (0 when gnt is zero)
// ---------------------------------------------------------------------------
module rr_arbiter
  import seq_det_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [idx_w(N)-1:0]   ptr,
  output logic [N-1:0]          gnt,
  output logic [idx_w(N)-1:0]   gidx
);

  localparam int IW = idx_w(N);

  logic          found;
  logic [IW-1:0] sel;

  always_comb begin
    gnt   = '0;
    gidx  = '0;
    found = 1'b0;
    sel   = '0;
    for (int off = 0; off < N; off++) begin
      sel = IW'((int'(ptr) + off) % N);
      if (!found && req[sel]) begin
        found    = 1'b1;
        gnt[sel] = 1'b1;
        gidx     = sel;
      end
    end
  end

endmodule

// File: rtl/seq_detect_arbiter.sv
// ---------------------------------------------------------------------------
// seq_detect_arbiter
// One pattern-detector datapath shared by NCH serial channels. A round-robin
// arbiter accepts at most one bit per cycle, advances that channel's saved
// history, pulses det_pulse on a match (overlaps allowed) and bumps a
// saturating per-channel hit counter. The 7-segment output rotates through
// the counters, one channel every DISP_DIV cycles.
//   clk         in   clock
//   reset       in   asynchronous active-high reset
//   bus         slave handshake: bit_in, bit_valid, bit_ready
//   clr_counts  in   synchronous clear of all hit counters
//   det_pulse   out  NCH one-cycle match pulses
//   disp_sel    out  channel currently shown
//   seg_out     out  {dp,g,f,e,d,c,b,a}; dp marks a saturated counter
// ---------------------------------------------------------------------------
module seq_detect_arbiter
  import seq_det_pkg::*;
#(
  parameter int              NCH      = 4,
  parameter int              PLEN     = DEF_PLEN,
  parameter logic [PLEN-1:0] PATTERN  = DEF_PATTERN,
  parameter int              CNT_W    = 4,
  parameter int              DISP_DIV = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  seq_detect_arbiter_if.slave      bus,
  input  logic                     clr_counts,
  output logic [NCH-1:0]           det_pulse,
  output logic [idx_w(NCH)-1:0]    disp_sel,
  output logic [7:0]               seg_out
);

  localparam int IW = idx_w(NCH);
  localparam int FW = $clog2(PLEN + 1);
  localparam int DW = idx_w(DISP_DIV);

  localparam logic [FW-1:0]    FILL_MAX = FW'(PLEN);
  localparam logic [FW-1:0]    FILL_ARM = FW'(PLEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IW-1:0]    LAST_CH  = IW'(NCH - 1);
  localparam logic [DW-1:0]    DIV_LAST = DW'(DISP_DIV - 1);

  // Arbitration
  logic [NCH-1:0] req;
  logic [NCH-1:0] gnt;
  logic [IW-1:0]  gidx;
  logic           xfer;
  logic [IW-1:0]  ptr_reg, ptr_next;

  // Requests are masked while reset is high so no bit is ever accepted then.
  assign req = reset ? '0 : bus.bit_valid;

  rr_arbiter #(.N(NCH)) u_arb (
    .req  (req),
    .ptr  (ptr_reg),
    .gnt  (gnt),
    .gidx (gidx)
  );

  assign bus.bit_ready = gnt;
  assign xfer          = |gnt;
  assign ptr_next      = !xfer ? ptr_reg :
                         (gidx == LAST_CH) ? '0 : gidx + 1'b1;

  // Per-channel context
  logic [NCH-1:0][PLEN-1:0]  hist_reg, hist_next;
  logic [NCH-1:0][FW-1:0]    fill_reg, fill_next;
  logic [NCH-1:0][CNT_W-1:0] cnt_reg, cnt_next;
  logic [NCH-1:0]            hit;
  logic [NCH-1:0]            det_reg;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic [PLEN-1:0] nh;
      assign nh = {hist_reg[gi][PLEN-2:0], bus.bit_in[gi]};

      // fill guards against the reset-zero history posing as real leading bits.
      assign hit[gi] = gnt[gi] && (nh == PATTERN) && (fill_reg[gi] >= FILL_ARM);

      assign hist_next[gi] = gnt[gi] ? nh : hist_reg[gi];
      assign fill_next[gi] = (gnt[gi] && (fill_reg[gi] != FILL_MAX)) ?
                             fill_reg[gi] + 1'b1 : fill_reg[gi];

      // Clear takes priority over a match in the same cycle.
      assign cnt_next[gi] = clr_counts ? '0 :
                            (hit[gi] && (cnt_reg[gi] != CNT_MAX)) ?
                            cnt_reg[gi] + 1'b1 : cnt_reg[gi];
    end
  endgenerate

  // Display rotation
  logic [DW-1:0]      div_reg, div_next;
  logic [IW-1:0]      disp_sel_reg, disp_sel_next;
  logic [7:0]         seg_reg, seg_next;
  logic [CNT_W-1:0]   sel_cnt;
  logic [CNT_W+3:0]   sel_ext;
  logic [3:0]         sel_nib;
  logic               div_wrap;

  assign div_wrap      = (div_reg == DIV_LAST);
  assign div_next      = div_wrap ? '0 : div_reg + 1'b1;
  assign disp_sel_next = !div_wrap ? disp_sel_reg :
                         (disp_sel_reg == LAST_CH) ? '0 : disp_sel_reg + 1'b1;

  // Zero-extend first so narrow counters pad and wide ones show the low nibble.
  assign sel_cnt  = cnt_reg[disp_sel_reg];
  assign sel_ext  = {4'b0000, sel_cnt};
  assign sel_nib  = sel_ext[3:0];
  assign seg_next = {((sel_cnt == CNT_MAX) ? SEG_DP_ON : 1'b0), hex7(sel_nib)};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_reg      <= '0;
      hist_reg     <= '0;
      fill_reg     <= '0;
      cnt_reg      <= '0;
      det_reg      <= '0;
      div_reg      <= '0;
      disp_sel_reg <= '0;
      seg_reg      <= SEG_RESET;
    end else begin
      ptr_reg      <= ptr_next;
      hist_reg     <= hist_next;
      fill_reg     <= fill_next;
      cnt_reg      <= cnt_next;
      det_reg      <= hit;
      div_reg      <= div_next;
      disp_sel_reg <= disp_sel_next;
      seg_reg      <= seg_next;
    end
  end

  assign det_pulse = det_reg;
  assign disp_sel  = disp_sel_reg;
  assign seg_out   = seg_reg;

endmodule
